ex_branch_resolve: RTL and testbench

//  EX-stage branch resolution unit. It consumes the comparator flags (less/equal) for the

---
 rtl/br_pkg.sv | 33 +++
 rtl/br_cond_eval.sv | 31 +++
 rtl/ex_branch_resolve.sv | 242 ++++++++++++++++++++++++
 tb/tb_ex_branch_resolve.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared definitions for branch resolution: funct3 encodings, resolver FSM
// states, the redirect bundle and small helpers used by EX and ID logic.
package br_pkg;

  // Native datapath width. The redirect bundle is sized to it.
  localparam int BR_XLEN = 32;

  // Conditional branch funct3 encodings (010/011 are not branches).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Resolver state: RUN resolves, FLUSH squashes younger instructions.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  // PC redirect request towards the IF-stage PC mux.
  typedef struct packed {
    logic               valid;
    logic [BR_XLEN-1:0] pc;
  } redirect_t;

  // A control-flow target is misaligned when either of its low two bits is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps funct3 plus comparator flags to the
// taken decision and drives the comparator's unsigned select. Purely
// combinational so the ID-stage predictor checks can reuse it.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       less,
  input  logic       equal,
  output logic       taken,
  output logic       br_un
);

  // BLTU/BGEU are the only encodings with funct3[1] set among real branches.
  assign br_un = funct3[1];

  // Decode the branch condition; reserved encodings never take.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = equal;
      F3_BNE:  taken = ~equal;
      F3_BLT:  taken = less;
      F3_BGE:  taken = ~less;
      F3_BLTU: taken = less;
      F3_BGEU: taken = ~less;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution unit. Resolves branches/JAL/JALR, compares the
// outcome with the IF prediction, issues a registered one-cycle PC redirect
// and holds the IF/ID and ID/EX flushes for FLUSH_CYCLES cycles.
// Optional feature: define BR_STATS_EN to add saturating event counters
// (o_stat_branches, o_stat_taken, o_stat_mispred).
module ex_branch_resolve
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = BR_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid_ex,
  input  logic            i_stall_ex,
  input  logic            i_is_branch_ex,
  input  logic            i_is_jal_ex,
  input  logic            i_is_jalr_ex,
  input  logic [2:0]      i_funct3_ex,
  input  logic            i_pred_taken_ex,
  input  logic [XLEN-1:0] i_pc_ex,
  input  logic [XLEN-1:0] i_imm_ex,
  input  logic [XLEN-1:0] i_rs1_data_ex,
  input  logic            i_br_less_ex,
  input  logic            i_br_equal_ex,
  output logic            o_br_un_ex,
  output logic [XLEN-1:0] o_link_data_ex,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush_if_id,
  output logic            o_flush_id_ex,
  output logic            o_misalign
`ifdef BR_STATS_EN
  ,
  output logic [XLEN-1:0] o_stat_branches,
  output logic [XLEN-1:0] o_stat_taken,
  output logic [XLEN-1:0] o_stat_mispred
`endif
);

  // The counter holds the remaining flush cycles after the first one.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);

  // ---------------------------------------------------------------------
  // Outcome and target computation
  // ---------------------------------------------------------------------
  logic            cond_taken_s;
  logic            is_ctrl_s;
  logic            resolve_s;
  logic            taken_s;
  logic [XLEN-1:0] fall_through_s;
  logic [XLEN-1:0] pc_rel_target_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            mispred_s;
  logic            misalign_s;
  logic            trigger_s;

  br_state_e       state_r;
  br_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  redirect_t       redirect_r;
  redirect_t       redirect_nxt_s;
  logic            misalign_r;
  logic            misalign_nxt_s;
  logic            flush_r;
  logic            flush_nxt_s;

  br_cond_eval u_cond (
    .funct3 (i_funct3_ex),
    .less   (i_br_less_ex),
    .equal  (i_br_equal_ex),
    .taken  (cond_taken_s),
    .br_un  (o_br_un_ex)
  );

  assign fall_through_s  = i_pc_ex + PC_STEP;
  assign pc_rel_target_s = i_pc_ex + i_imm_ex;
  assign jalr_sum_s      = i_rs1_data_ex + i_imm_ex;
  assign o_link_data_ex  = fall_through_s;

  assign is_ctrl_s = i_is_branch_ex | i_is_jal_ex | i_is_jalr_ex;
  // Instructions reaching EX while flushing are squashed, so only RUN resolves.
  assign resolve_s = (state_r == RUN) & i_valid_ex & ~i_stall_ex & is_ctrl_s;

  // Select actual direction and target; jumps are always taken.
  always_comb begin
    taken_s  = 1'b0;
    target_s = pc_rel_target_s;
    if (i_is_jalr_ex) begin
      taken_s  = 1'b1;
      target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else if (i_is_jal_ex) begin
      taken_s  = 1'b1;
      target_s = pc_rel_target_s;
    end else if (i_is_branch_ex) begin
      taken_s  = cond_taken_s;
      target_s = pc_rel_target_s;
    end else begin
      taken_s  = 1'b0;
      target_s = pc_rel_target_s;
    end
  end

  // Classify the resolve event: mispredict, misaligned taken target, or clean.
  always_comb begin
    mispred_s = 1'b0;
    if (resolve_s) begin
      if (i_is_jalr_ex) begin
        mispred_s = 1'b1;
      end else if (i_is_jal_ex) begin
        mispred_s = ~i_pred_taken_ex;
      end else begin
        mispred_s = (taken_s != i_pred_taken_ex);
      end
    end else begin
      mispred_s = 1'b0;
    end
    misalign_s    = resolve_s & taken_s & is_misaligned(target_s[1:0]);
    trigger_s     = mispred_s | misalign_s;
    redirect_pc_s = taken_s ? target_s : fall_through_s;
  end

  // ---------------------------------------------------------------------
  // Resolver FSM
  // ---------------------------------------------------------------------

  // State and flush-counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state: enter FLUSH on a redirect/trap event; count down regardless of stall.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (trigger_s) begin
          state_nxt_s = FLUSH;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      FLUSH: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = FLUSH;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Next output values: a misaligned target traps instead of redirecting.
  always_comb begin
    redirect_nxt_s.valid = trigger_s & ~misalign_s;
    if (trigger_s) begin
      redirect_nxt_s.pc = redirect_pc_s;
    end else begin
      redirect_nxt_s.pc = redirect_r.pc;
    end
    misalign_nxt_s = misalign_s;
    flush_nxt_s    = (state_nxt_s == FLUSH);
  end

  // Output register; reset drops any pending redirect immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      redirect_r <= '{valid: 1'b0, pc: {BR_XLEN{1'b0}}};
      misalign_r <= 1'b0;
      flush_r    <= 1'b0;
    end else begin
      redirect_r <= redirect_nxt_s;
      misalign_r <= misalign_nxt_s;
      flush_r    <= flush_nxt_s;
    end
  end

  assign o_redirect_valid = redirect_r.valid;
  assign o_redirect_pc    = redirect_r.pc;
  assign o_misalign       = misalign_r;
  assign o_flush_if_id    = flush_r;
  assign o_flush_id_ex    = flush_r;

`ifdef BR_STATS_EN
  // ---------------------------------------------------------------------
  // Event statistics
  // ---------------------------------------------------------------------
  localparam logic [XLEN-1:0] STAT_MAX = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] STAT_ONE = XLEN'(32'd1);

  logic [XLEN-1:0] stat_branches_r;
  logic [XLEN-1:0] stat_taken_r;
  logic [XLEN-1:0] stat_mispred_r;

  // Saturating counters for resolve, taken and mispredict events.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_branches_r <= {XLEN{1'b0}};
      stat_taken_r    <= {XLEN{1'b0}};
      stat_mispred_r  <= {XLEN{1'b0}};
    end else begin
      if (resolve_s && (stat_branches_r != STAT_MAX)) begin
        stat_branches_r <= stat_branches_r + STAT_ONE;
      end
      if (resolve_s && taken_s && (stat_taken_r != STAT_MAX)) begin
        stat_taken_r <= stat_taken_r + STAT_ONE;
      end
      if (mispred_s && (stat_mispred_r != STAT_MAX)) begin
        stat_mispred_r <= stat_mispred_r + STAT_ONE;
      end
    end
  end

  assign o_stat_branches = stat_branches_r;
  assign o_stat_taken    = stat_taken_r;
  assign o_stat_mispred  = stat_mispred_r;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Scoreboard bench for ex_branch_resolve: stimulus pushes expected redirect /
// misalign events and flush lengths; a monitor pops and compares whenever the
// DUT presents an event.
module tb_ex_branch_resolve;
  import br_pkg::*;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        valid, stall, is_br, is_jal, is_jalr, pred, less, equal;
  logic [2:0]  funct3;
  logic [31:0] pc, imm, rs1;
  logic        br_un;
  logic [31:0] link;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic        fl_if_id, fl_id_ex, misalign;
`ifdef BR_STATS_EN
  logic [31:0] st_br, st_tk, st_mp;
`endif

  typedef struct packed {
    logic        rv;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   flush_q[$];
  int   total;
  int   bad;

  ex_branch_resolve #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid_ex       (valid),
    .i_stall_ex       (stall),
    .i_is_branch_ex   (is_br),
    .i_is_jal_ex      (is_jal),
    .i_is_jalr_ex     (is_jalr),
    .i_funct3_ex      (funct3),
    .i_pred_taken_ex  (pred),
    .i_pc_ex          (pc),
    .i_imm_ex         (imm),
    .i_rs1_data_ex    (rs1),
    .i_br_less_ex     (less),
    .i_br_equal_ex    (equal),
    .o_br_un_ex       (br_un),
    .o_link_data_ex   (link),
    .o_redirect_valid (rd_valid),
    .o_redirect_pc    (rd_pc),
    .o_flush_if_id    (fl_if_id),
    .o_flush_id_ex    (fl_id_ex),
    .o_misalign       (misalign)
`ifdef BR_STATS_EN
    ,
    .o_stat_branches  (st_br),
    .o_stat_taken     (st_tk),
    .o_stat_mispred   (st_mp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // Apply one cycle of EX inputs just after the rising edge.
  task automatic drive(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic pr,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                       input logic lt, input logic eq, input logic st);
    @(posedge clk);
    #1;
    valid = v; is_br = br; is_jal = jal; is_jalr = jalr; funct3 = f3; pred = pr;
    pc = p; imm = im; rs1 = r1; less = lt; equal = eq; stall = st;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_event(input logic rv, input logic mis, input logic [31:0] tpc);
    exp_q.push_back('{rv: rv, mis: mis, pc: tpc});
    flush_q.push_back(FC);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_redirect_valid"}, {31'b0, rd_valid}, 32'h0);
    check({tag, "_redirect_pc"}, rd_pc, 32'h0);
    check({tag, "_flush"}, {30'b0, fl_if_id, fl_id_ex}, 32'h0);
    check({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
`ifdef BR_STATS_EN
    check({tag, "_stats"}, st_br | st_tk | st_mp, 32'h0);
`endif
  endtask

  // Monitor: compare every presented event and every flush burst length.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (rd_valid || misalign) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {30'b0, rd_valid, misalign}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("redirect_valid", {31'b0, rd_valid}, {31'b0, e.rv});
            check("misalign", {31'b0, misalign}, {31'b0, e.mis});
            check("redirect_pc", rd_pc, e.pc);
          end
        end
        if (fl_if_id || fl_id_ex) begin
          check("flush_pair", {31'b0, fl_id_ex}, {31'b0, fl_if_id});
          run++;
        end else if (run > 0) begin
          if (flush_q.size() == 0) check("unexpected_flush", run, 32'h0);
          else                     check("flush_len", run, flush_q.pop_front());
          run = 0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    valid = 1'b0; stall = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    pred = 1'b0; less = 1'b0; equal = 1'b0; funct3 = 3'b000;
    pc = 32'h0; imm = 32'h0; rs1 = 32'h0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1; rst = 1'b0;

    // BEQ taken, predicted not taken -> redirect to pc+imm.
    expect_event(1'b1, 1'b0, 32'h0000_0120);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BEQ, 1'b0, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("beq_link", link, 32'h0000_0104);
    check("beq_br_un", {31'b0, br_un}, 32'h0);
    idle(5);

    // BLTU taken, predicted taken -> nothing.
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BLTU, 1'b1, 32'h180, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    check("bltu_br_un", {31'b0, br_un}, 32'h1);
    idle(4);

    // BNE not taken, predicted taken -> fall-through.
    expect_event(1'b1, 1'b0, 32'h0000_0204);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BNE, 1'b1, 32'h200, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // JALR to 0x1006: bit 0 cleared, still misaligned -> trap, no redirect.
    expect_event(1'b0, 1'b1, 32'h0000_1006);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h300, 32'h4, 32'h1003, 1'b0, 1'b0, 1'b0);
    #1;
    check("jalr_link", link, 32'h0000_0304);
    idle(5);

    // JAL not predicted -> redirect with negative offset.
    expect_event(1'b1, 1'b0, 32'h0000_04F0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h500, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // JAL predicted taken -> nothing.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 32'h600, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // BLT not taken, predicted taken -> fall-through.
    expect_event(1'b1, 1'b0, 32'h0000_0704);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BLT, 1'b1, 32'h700, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Reserved funct3 010 never taken; predicted taken -> fall-through.
    expect_event(1'b1, 1'b0, 32'h0000_0804);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 32'h800, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
    #1;
    check("f3_010_br_un", {31'b0, br_un}, 32'h1);
    idle(5);

    // BGE taken, predicted taken -> nothing.
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BGE, 1'b1, 32'h900, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Aligned JALR: (0x2001+7)&~1 = 0x2008.
    expect_event(1'b1, 1'b0, 32'h0000_2008);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h980, 32'h7, 32'h2001, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Mispredict, then a stalled mispredicting branch during FLUSH is ignored.
    expect_event(1'b1, 1'b0, 32'h0000_0408);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BEQ, 1'b0, 32'h400, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
    repeat (FC) drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BNE, 1'b0, 32'hA00, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Same, with the younger branch unstalled: still squashed.
    expect_event(1'b1, 1'b0, 32'h0000_0A80);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BGEU, 1'b0, 32'hA40, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (FC) drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BNE, 1'b0, 32'hB00, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Reset raised the cycle after a mispredict: redirect and flush vanish.
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BEQ, 1'b0, 32'hB80, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    check_outputs_zero("midflush_reset");
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // Back in RUN: a fresh mispredict redirects normally.
    expect_event(1'b1, 1'b0, 32'h0000_0C10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, F3_BEQ, 1'b0, 32'hC00, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(6);

    check("events_drained", exp_q.size(), 32'h0);
    check("flushes_drained", flush_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
